// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ producers.
// Define UART_ARB_HDR_EN to send an 8'hA0|id header byte ahead of each data byte.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [8*N_REQ-1:0]   data_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic [ID_W-1:0]      grant_id_o,
    output logic                 busy_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_done_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
`ifdef UART_ARB_HDR_EN
        S_HDR_START,
        S_HDR_WAIT,
`endif
        S_ACK
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_q;
    logic [7:0]      data_q;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] cand;
    logic            pick_hit;

    // Search upward from last_grant+1; ID_W-bit add wraps modulo N_REQ.
    always_comb begin
        pick_id  = '0;
        pick_hit = 1'b0;
        cand     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last_grant + ID_W'(i);
            if (!pick_hit && req_i[cand]) begin
                pick_hit = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_W'(N_REQ - 1);
            grant_q    <= '0;
            data_q     <= 8'h00;
        end else begin
            if (state == S_IDLE && pick_hit) begin
                grant_q <= pick_id;
                data_q  <= data_i[{pick_id, 3'b000} +: 8];
            end
            if (state == S_ACK) begin
                last_grant <= grant_q;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        tx_start_o = 1'b0;
        tx_data_o  = data_q;
        ack_o      = '0;
        unique case (state)
            S_IDLE: begin
                if (pick_hit) begin
`ifdef UART_ARB_HDR_EN
                    state_nx = S_HDR_START;
`else
                    state_nx = S_START;
`endif
                end
            end
            S_START: begin
                tx_start_o = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_i) begin
                    state_nx = S_ACK;
                end
            end
`ifdef UART_ARB_HDR_EN
            S_HDR_START: begin
                tx_start_o = 1'b1;
                tx_data_o  = 8'hA0 | 8'(grant_q);
                state_nx   = S_HDR_WAIT;
            end
            S_HDR_WAIT: begin
                tx_data_o = 8'hA0 | 8'(grant_q);
                if (tx_done_i) begin
                    state_nx = S_START;
                end
            end
`endif
            S_ACK: begin
                ack_o[grant_q] = 1'b1;
                state_nx       = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy_o     = (state != S_IDLE);
    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus
// hand sequences for fairness, reset mid-transfer and the header build.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic [3:0]  ack_o;
    logic [1:0]  grant_id_o;
    logic        busy_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .data_i     (data),
        .ack_o      (ack_o),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_done_i  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  q;
        logic [31:0] d;
        logic        dn;
        logic [3:0]  a;
        logic        s;
        logic [7:0]  x;
        logic        b;
        logic [1:0]  g;
    } vec_t;

    vec_t vq[$];

    function automatic void v(logic r, logic [3:0] q, logic [31:0] d,
                              logic dn, logic [3:0] a, logic s,
                              logic [7:0] x, logic b, logic [1:0] g);
        vec_t e;
        e = '{r, q, d, dn, a, s, x, b, g};
        vq.push_back(e);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({nm, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0;
        done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    localparam logic [31:0] D4 = 32'h44332211;

    initial begin
        logic [3:0] m;
        logic [7:0] b;
        logic [1:0] g;
        rst  = 1'b1;
        req  = 4'b0;
        data = 32'h0;
        done = 1'b0;

        // reset state
        v(1, 4'b0000, 32'h0, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
`ifndef UART_ARB_HDR_EN
        // single request
        v(0, 4'b0001, 32'h55, 0, 4'b0000, 1, 8'h55, 1, 2'd0);
        v(0, 4'b0001, 32'h55, 0, 4'b0000, 0, 8'h55, 1, 2'd0);
        v(0, 4'b0001, 32'h55, 1, 4'b0001, 0, 8'h55, 1, 2'd0);
        v(0, 4'b0001, 32'h55, 0, 4'b0000, 0, 8'h55, 0, 2'd0);
        v(0, 4'b0000, 32'h55, 0, 4'b0000, 0, 8'h55, 0, 2'd0);
        // spurious done in IDLE and START
        v(0, 4'b0000, 32'h0,  1, 4'b0000, 0, 8'h55, 0, 2'd0);
        v(0, 4'b0001, 32'h5A, 1, 4'b0000, 1, 8'h5A, 1, 2'd0);
        v(0, 4'b0001, 32'h5A, 1, 4'b0000, 0, 8'h5A, 1, 2'd0);
        v(0, 4'b0001, 32'h5A, 0, 4'b0000, 0, 8'h5A, 1, 2'd0);
        v(0, 4'b0001, 32'h5A, 1, 4'b0001, 0, 8'h5A, 1, 2'd0);
        v(0, 4'b0001, 32'h5A, 0, 4'b0000, 0, 8'h5A, 0, 2'd0);
        // simultaneous requests, each drops after its ack
        v(1, 4'b0000, 32'h0, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            m = 4'b1111 << k;
            b = 8'h11 * 8'(k + 1);
            g = 2'(k);
            v(0, m, D4, 0, 4'b0000, 1, b, 1, g);
            v(0, m, D4, 0, 4'b0000, 0, b, 1, g);
            v(0, m, D4, 1, 4'b0001 << k, 0, b, 1, g);
            v(0, m, D4, 0, 4'b0000, 0, b, 0, g);
        end
        v(0, 4'b0000, D4, 0, 4'b0000, 0, 8'h44, 0, 2'd3);
`endif

        foreach (vq[i]) begin
            rst  = vq[i].r;
            req  = vq[i].q;
            data = vq[i].d;
            done = vq[i].dn;
            step();
            chk($sformatf("vec%0d", i),
                {ack_o, tx_start_o, tx_data_o, busy_o, grant_id_o},
                {vq[i].a, vq[i].s, vq[i].x, vq[i].b, vq[i].g});
        end
        done = 1'b0;

`ifndef UART_ARB_HDR_EN
        // fairness: requesters 0 and 2 always requesting
        do_reset();
        req  = 4'b0101;
        data = D4;
        for (int n = 0; n < 4; n++) begin
            wait_start($sformatf("fair%0d", n));
            chk($sformatf("fair%0d_gid", n), 32'(grant_id_o), (n % 2) * 2);
            chk($sformatf("fair%0d_byte", n), 32'(tx_data_o),
                (n % 2 == 0) ? 32'h11 : 32'h33);
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            chk($sformatf("fair%0d_ack", n), 32'(ack_o),
                (n % 2 == 0) ? 32'h1 : 32'h4);
            step();
        end
        req = 4'b0000;
        step();

        // reset 50 clocks into a transfer
        do_reset();
        req  = 4'b0001;
        data = D4;
        wait_start("rstw");
        for (int i = 0; i < 50; i++) begin
            step();
            if (ack_o != 4'b0) chk("rstw_early_ack", 32'(ack_o), 32'h0);
        end
        rst = 1'b1;
        req = 4'b1010;
        step();
        chk("rstw_outs", {ack_o, tx_start_o, tx_data_o, busy_o, grant_id_o},
            {4'b0000, 1'b0, 8'h00, 1'b0, 2'd0});
        rst = 1'b0;
        step();
        chk("rstw_regrant",
            {ack_o, tx_start_o, tx_data_o, busy_o, grant_id_o},
            {4'b0000, 1'b1, 8'h22, 1'b1, 2'd1});
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("rstw_ack", 32'(ack_o), 32'h2);
        req = 4'b0000;
        step();
        chk("rstw_idle", 32'(busy_o), 32'h0);
`else
        // header build: two start pulses, one ack
        do_reset();
        req  = 4'b0100;
        data = 32'h003C0000;
        wait_start("hdr_a");
        chk("hdr_byte", 32'(tx_data_o), 32'hA2);
        chk("hdr_gid", 32'(grant_id_o), 32'd2);
        step();
        chk("hdr_hold", 32'(tx_data_o), 32'hA2);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("hdr_noack", 32'(ack_o), 32'h0);
        wait_start("hdr_b");
        chk("hdr_data", 32'(tx_data_o), 32'h3C);
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("hdr_ack", 32'(ack_o), 32'h4);
        req = 4'b0000;
        step();
        chk("hdr_ack_off", 32'(ack_o), 32'h0);
        chk("hdr_idle", 32'(busy_o), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` serializer between `N_REQ` byte producers. It accepts level requests, latches the winning requester's byte and issues a start pulse to the transmitter. It then waits for the transmitter's done pulse and returns a one-cycle acknowledge to the winner. It sits between the application producers and the single UART transmit pin, on the same 10-clocks-per-bit UART clock domain as `uart_rx`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; power of two, 2..8.
- `ID_W`, 2: grant index width; must equal $clog2(N_REQ).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_i`  in  N_REQ  level request per requester; held high until that requester's `ack_o` bit pulses.
- `data_i`  in  8*N_REQ  byte k at [8k+7:8k]; stable while `req_i[k]` is high.
- `ack_o`  out  N_REQ  one-cycle pulse on bit k when requester k's byte has completed its stop bit.
- `grant_id_o`  out  ID_W  index of the requester currently being served.
- `busy_o`  out  1  high in every state except IDLE.
- `tx_start_o`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data_o`  out  8  byte to `uart_tx`; held stable from the start pulse until the matching done pulse.
- `tx_done_i`  in  1  one-cycle pulse from `uart_tx` at the end of the stop bit.

## Operation
- States: IDLE, START, WAIT, ACK. With the header feature, HDR_START and HDR_WAIT are added.
- IDLE:
  - If `req_i != 0`, select the first set bit searching upward from `last_grant+1`, wrapping modulo N_REQ.
  - Latch its index into `grant_id_o` and its byte into an internal register.
  - Go to START, or HDR_START when the header feature is enabled.
- START: `tx_start_o=1`, `tx_data_o`=latched byte; go to WAIT.
- WAIT: hold outputs. On `tx_done_i`, go to ACK.
- ACK: `ack_o[grant_id_o]=1`; set `last_grant<=grant_id_o`; go to IDLE.
- `tx_done_i` is ignored in IDLE, START and ACK; it never produces an ack.
- Requester protocol: a requester drops `req_i` on the edge that samples `ack_o` high. The following IDLE cycle therefore sees the updated request.
- Deassertion of `req_i` during START/WAIT is ignored. The transfer completes and the ack is still issued.
- `data_i` changes after the grant cycle have no effect.

## Timing
- Reset values:
  - state IDLE, `last_grant=N_REQ-1` (requester 0 wins first).
  - `ack_o=0`, `tx_start_o=0`, `tx_data_o=8'h00`, `grant_id_o=0`, `busy_o=0`.
- Request latency: `req_i` high in IDLE cycle t gives `tx_start_o` high in cycle t+1. From cycle t+1, `busy_o=1`.
- Ack latency: `tx_done_i` in cycle d gives `ack_o` in d+1 and IDLE in d+2. The next `tx_start_o` comes no earlier than d+3.
- At most one `ack_o` bit is high in any cycle, and `tx_start_o` never pulses in two consecutive cycles.
- Reset mid-transfer (any state) returns to the reset values on the next edge. No ack is issued for the aborted byte, and priority restarts at requester 0.
- One frame = 10 bits × 10 clocks = 100 clocks from start to done when driven by `uart_tx`.

## Configuration
- `UART_ARB_HDR_EN` defined: each grant sends two bytes.
  - HDR_START drives `tx_start_o` with `tx_data_o = 8'hA0 | grant_id_o`.
  - HDR_WAIT waits for `tx_done_i`, then goes to START for the data byte.
  - Only the data byte's done produces the ack.
  - Ack latency grows by one full frame plus one cycle.
- Not defined: HDR states are absent and one byte is sent per grant, as described above.

## Test plan
- Single request: after reset, `req_i=4'b0001`, `data_i[7:0]=8'h55` -> `tx_start_o` one cycle later with `tx_data_o=8'h55`. After `tx_done_i`, `ack_o=4'b0001` for exactly one cycle, then `busy_o=0`.
- Simultaneous requests: `req_i=4'b1111` with bytes 0x11,0x22,0x33,0x44 -> transmitted order 0x11,0x22,0x33,0x44. Acks go 0001,0010,0100,1000.
- Fairness: requesters 0 and 2 re-request immediately after each ack -> grants alternate 0,2,0,2. Neither requester gets two consecutive grants.
- Reset mid-WAIT: pulse `rst` 50 clocks after `tx_start_o` -> all outputs reset values next cycle and no ack. With `req_i=4'b1010` afterwards, requester 1 is granted first.
- Spurious done: `tx_done_i` pulsed in IDLE and START -> `ack_o` stays 0 and the FSM still waits for a done in WAIT.
- Header build (`UART_ARB_HDR_EN`): `req_i=4'b0100`, byte 0x3C -> `tx_start_o` twice, first with 0xA2 and then with 0x3C. A single `ack_o=4'b0100` follows the second done.
